nbit_serializer: RTL and testbench



---
 rtl/nbit_serializer.sv | 118 +++++++++++
 tb/tb_nbit_serializer.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/nbit_serializer.sv
// nbit_serializer: parallel-in, serial-out transmitter for N-bit words.
// A word is accepted over a valid/ready handshake and then sent MSB-first,
// one bit per clock, with a qualifying valid strobe. Back-to-back frames
// need no idle gap: the next word can be accepted in the last-bit cycle.
//
// Optional feature: define PARITY_EN to append an even-parity bit (XOR of
// the accepted word) after the N data bits, giving frames of N+1 bits.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   in0         parallel word, sampled only on an accepted load
//   load_valid  upstream presents a word on in0
//   load_ready  a word can be accepted this cycle
//   sout        serial data bit, MSB first (0 when idle)
//   sout_valid  sout carries a frame bit this cycle
//   busy        a frame is in progress
//   done        one-cycle pulse coincident with the last bit of a frame
module nbit_serializer #(
  parameter int unsigned N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] in0,
  input  logic         load_valid,
  output logic         load_ready,
  output logic         sout,
  output logic         sout_valid,
  output logic         busy,
  output logic         done
);

`ifdef PARITY_EN
  localparam int unsigned F = N + 1;
`else
  localparam int unsigned F = N;
`endif
  localparam int unsigned CW = $clog2(N + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [F-1:0]  r_shift;
  logic [F-1:0]  w_shift_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [F-1:0]  w_load_word;
  logic          w_last;
  logic          w_accept;

  // Frame image loaded at accept; the parity bit rides in the LSB so it
  // falls out of the shift register right after the data bits.
`ifdef PARITY_EN
  assign w_load_word = {in0, ^in0};
`else
  assign w_load_word = in0;
`endif

  assign w_last     = (r_state == SHIFT) && (r_cnt == '0);
  assign load_ready = (r_state == IDLE) || w_last;
  assign w_accept   = load_valid && load_ready;

  // Outputs derive only from registered state.
  assign sout       = (r_state == SHIFT) && r_shift[F-1];
  assign sout_valid = (r_state == SHIFT);
  assign busy       = (r_state == SHIFT);
  assign done       = w_last;

  // State register and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = SHIFT;
          w_shift_nxt = w_load_word;
          w_cnt_nxt   = CW'(F - 1);
        end
      end
      SHIFT: begin
        if (w_accept) begin
          // Only possible in the last-bit cycle: reload for a gapless frame.
          w_shift_nxt = w_load_word;
          w_cnt_nxt   = CW'(F - 1);
        end else if (w_last) begin
          w_state_nxt = IDLE;
          w_shift_nxt = {r_shift[F-2:0], 1'b0};
        end else begin
          w_shift_nxt = {r_shift[F-2:0], 1'b0};
          w_cnt_nxt   = r_cnt - CW'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_nbit_serializer.sv
// Directed bench for nbit_serializer (N = 16). Expected bit streams come
// from the hand-picked words; the parity bit is appended when PARITY_EN is
// defined for both bench and design.
module tb_nbit_serializer;

  localparam int unsigned N = 16;
`ifdef PARITY_EN
  localparam int unsigned F = N + 1;
`else
  localparam int unsigned F = N;
`endif

  logic         clk;
  logic         rst_n;
  logic [N-1:0] in0;
  logic         load_valid;
  logic         load_ready;
  logic         sout;
  logic         sout_valid;
  logic         busy;
  logic         done;

  int n_total;
  int n_bad;

  nbit_serializer #(.N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in0        (in0),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .sout       (sout),
    .sout_valid (sout_valid),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_sout"},  32'(sout),       32'd0);
    chk({tag, "_svld"},  32'(sout_valid), 32'd0);
    chk({tag, "_busy"},  32'(busy),       32'd0);
    chk({tag, "_done"},  32'(done),       32'd0);
    chk({tag, "_ready"}, 32'(load_ready), 32'd1);
  endtask

  // Check a frame of word w whose MSB is on sout now. At bit index
  // drive_at the bench raises load_valid with nw (held to frame end).
  task automatic chk_frame(input string tag, input logic [N-1:0] w,
                           input int drive_at, input logic [N-1:0] nw);
    logic exp_bit;
    for (int i = 0; i < int'(F); i++) begin
      if (i == drive_at) begin
        in0        = nw;
        load_valid = 1'b1;
        #1;
      end
      if (i < int'(N)) exp_bit = w[N-1-i];
      else             exp_bit = ^w;
      chk($sformatf("%s_b%0d_sout", tag, i),  32'(sout),       32'(exp_bit));
      chk($sformatf("%s_b%0d_svld", tag, i),  32'(sout_valid), 32'd1);
      chk($sformatf("%s_b%0d_busy", tag, i),  32'(busy),       32'd1);
      chk($sformatf("%s_b%0d_done", tag, i),  32'(done),       32'(i == int'(F) - 1));
      chk($sformatf("%s_b%0d_rdy", tag, i),   32'(load_ready), 32'(i == int'(F) - 1));
      tick();
    end
  endtask

  // Present a word for one accepting edge, then drop load_valid.
  task automatic load(input logic [N-1:0] w);
    in0        = w;
    load_valid = 1'b1;
    chk("load_rdy", 32'(load_ready), 32'd1);
    tick();
    load_valid = 1'b0;
  endtask

  initial begin
    n_total    = 0;
    n_bad      = 0;
    rst_n      = 1'b0;
    in0        = '0;
    load_valid = 1'b0;

    // Reset held for three cycles, then idle with no load.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_idle($sformatf("rst%0d", i));
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_idle($sformatf("idle%0d", i));
    end

    // Single frame 1010_0101_1100_0011 (parity 0), then back to idle.
    load(16'hA5C3);
    chk_frame("a5c3", 16'hA5C3, -1, '0);
    chk_idle("a5c3_end");

    // 15 zeros, then 1 (then parity 1 when enabled).
    load(16'h0001);
    chk_frame("p0001", 16'h0001, -1, '0);
    chk_idle("p0001_end");

    // Back-to-back: FFFF then 0000 held -> continuous valid, done twice.
    load(16'hFFFF);
    chk_frame("b2b_ffff", 16'hFFFF, 0, 16'h0000);
    load_valid = 1'b0;
    chk_frame("b2b_0000", 16'h0000, -1, '0);
    chk_idle("b2b_end");

    // Load raised during bit 3 is ignored until the last-bit cycle.
    load(16'hA5C3);
    chk_frame("busy_a5c3", 16'hA5C3, 2, 16'h1234);
    load_valid = 1'b0;
    in0        = 16'hDEAD;
    chk_frame("busy_1234", 16'h1234, -1, '0);
    chk_idle("busy_end");

    // Reset asserted during bit 5 clears outputs without a clock edge.
    load(16'hA5C3);
    for (int i = 0; i < 4; i++) tick();
    chk("mid_busy_pre", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle("midrst");
    tick();
    chk_idle("midrst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_idle("midrst_rel");
    load(16'h8000);
    chk_frame("post_8000", 16'h8000, -1, '0);
    chk_idle("post_end");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
